io_port_bridge: RTL and testbench
=================================

# io_port_bridge

Host-side bridge attached to the stack processor's 16-bit I/O pins. It drives the processor's `input_IO` from a host-written register. It also watches the processor's `output_IO` and detects each new stable value. Each such value is pushed into a show-ahead FIFO that the host drains with a read strobe. The bridge sits beside the processor top level in system and testbench builds, and is the reader/driver end of the processor's I/O interface.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `STABLE_CYCLES`, 2: consecutive samples a new `output_IO` value must hold before it is captured; legal range 1..15.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `output_IO`  in  16  processor output port; sampled every cycle.
- `input_IO`  out  16  processor input port; registered.
- `host_in_data`  in  16  value to present on `input_IO`.
- `host_in_we`  in  1  load `host_in_data` into `input_IO` at the next edge.
- `host_rd_en`  in  1  pop the FIFO head at the next edge (ignored when empty).
- `host_rd_data`  out  16  FIFO head (show-ahead); 0 when empty.
- `host_rd_valid`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(DEPTH)+1  number of stored entries.
- `dropped`  out  1  sticky: a capture was lost because the FIFO was full.
- `host_clear_drop`  in  1  clear `dropped` at the next edge.

## Operation
- Reset values:
  - `input_IO`=0, `host_rd_data`=0, `host_rd_valid`=0, `fifo_count`=0, `dropped`=0.
  - FIFO pointers 0.
  - `last_val`=0x0000 (matches processor output reset value).
  - FSM in WATCH, `cand`=0, `cnt`=0.
- Input side: `input_IO` <= `host_in_data` on every edge with `host_in_we`=1. Otherwise it holds.
- Capture FSM, two states:
  - WATCH:
    - If `output_IO`==`last_val`, stay.
    - Else if STABLE_CYCLES==1, push `output_IO`, set `last_val`<=`output_IO`, stay in WATCH.
    - Else `cand`<=`output_IO`, `cnt`<=1, go to SETTLE.
  - SETTLE:
    - If `output_IO`==`last_val`, go to WATCH with no push (glitch rejected).
    - Else if `output_IO`!=`cand`, set `cand`<=`output_IO`, `cnt`<=1, stay (restart).
    - Else if `cnt`+1==STABLE_CYCLES, push `cand`, set `last_val`<=`cand`, go to WATCH.
    - Else `cnt`<=`cnt`+1.
- Push when full (and no pop in the same cycle):
  - The entry is discarded and `dropped`<=1.
  - `last_val` is still updated, so the value is not re-captured.
- Pop: `host_rd_en`=1 with `host_rd_valid`=1 advances the read pointer. `host_rd_en` while empty has no effect.
- Push and pop in the same edge:
  - When full: both occur and `fifo_count` is unchanged. There is no drop.
  - When empty: only the push occurs.
- Pointers wrap modulo DEPTH. `fifo_count` saturates at DEPTH and never exceeds it.
- `dropped`: a drop and `host_clear_drop` in the same edge leave `dropped`=1 (set wins).
- Repeated writes of the same value by the processor are indistinguishable and produce one capture. This is intended.

## Timing
- `output_IO` is treated as a plain signal and compared combinationally with registered state. It must be synchronous to `clk`.
- Capture latency:
  - A new value first sampled at edge k is pushed at edge k+STABLE_CYCLES-1.
  - `host_rd_valid` rises after that edge when the FIFO was empty.
- `host_rd_data` updates in the same edge as a pop or as a push into an empty FIFO. There is zero-cycle show-ahead after the edge.
- `input_IO` is valid one edge after `host_in_we`.
- Asserting `reset` mid-SETTLE abandons the candidate and discards all FIFO contents. Outputs go to their reset values without waiting for a clock edge.

## Test plan
- Reset then idle: hold `output_IO`=0 for 20 cycles -> `host_rd_valid`=0, `fifo_count`=0, `input_IO`=0.
- Basic capture, STABLE_CYCLES=2: set `output_IO`=0x1234 and hold -> push one edge after first sample, `host_rd_data`=0x1234, `fifo_count`=1. Pulse `host_rd_en` -> count 0, valid 0.
- Glitch reject: set `output_IO`=0x00AA for one cycle, then 0x0000 -> no push. Then 0x00AA, 0x00BB, 0x00BB -> single capture of 0x00BB.
- Overflow, DEPTH=8: capture 9 distinct stable values without reading -> `fifo_count`=8, `dropped`=1, head = first value. `host_clear_drop` -> `dropped`=0. A 10th capture with simultaneous `host_rd_en` -> no drop, count stays 8.
- Wrap-around: perform 20 capture/read pairs with values 1..20 -> read sequence exactly 1..20 in order, pointers wrapped twice.
- Input and reset: `host_in_we` with 0xBEEF -> `input_IO`=0xBEEF next edge. Assert `reset` mid-SETTLE with 3 entries queued -> all outputs 0 immediately. After release, a new stable value is captured normally.

Source files
------------

// File: rtl/io_port_bridge.sv
// io_port_bridge: drives processor input_IO from a host register and queues each new stable output_IO value in a show-ahead FIFO
// Ports: clk/reset (async, active-high); output_IO sampled every cycle; input_IO loaded from host_in_data on host_in_we;
// host_rd_en pops host_rd_data/host_rd_valid; fifo_count entries stored; dropped is sticky overflow, cleared by host_clear_drop.
module io_port_bridge #(
   parameter int DEPTH         = 8,
   parameter int STABLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [15:0]            output_IO,
   output logic [15:0]            input_IO,
   input  logic [15:0]            host_in_data,
   input  logic                   host_in_we,
   input  logic                   host_rd_en,
   output logic [15:0]            host_rd_data,
   output logic                   host_rd_valid,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   dropped,
   input  logic                   host_clear_drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0] SC = 4'(STABLE_CYCLES);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   typedef enum logic {WATCH, SETTLE} state_t;
   state_t state;
   logic [15:0] last_val, cand;
   logic [3:0] cnt;
   logic [15:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic push, pop, full, do_push;
   // push_val is always output_IO: in SETTLE a push only happens when output_IO equals cand
   assign push = output_IO != last_val && (state == WATCH ? STABLE_CYCLES == 1 : output_IO == cand && cnt + 4'd1 == SC);
   assign host_rd_valid = fifo_count != '0;
   assign host_rd_data = host_rd_valid ? mem[rd_ptr] : '0;
   assign pop = host_rd_en && host_rd_valid;
   assign full = fifo_count == FULL;
   assign do_push = push && (!full || pop);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= WATCH;
         cand <= '0;
         cnt <= '0;
         last_val <= '0;
      end else if (state == WATCH) begin
         if (output_IO != last_val) begin
            if (push) last_val <= output_IO;
            else begin
               cand <= output_IO;
               cnt <= 4'd1;
               state <= SETTLE;
            end
         end
      end else begin
         if (output_IO == last_val) state <= WATCH;
         else if (output_IO != cand) begin
            cand <= output_IO;
            cnt <= 4'd1;
         end else if (push) begin
            last_val <= cand;
            state <= WATCH;
         end else cnt <= cnt + 4'd1;
      end
   end
   // last_val advances even on a dropped push so the lost value is not re-captured
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_count <= '0;
         dropped <= 1'b0;
         input_IO <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count + CW'(do_push) - CW'(pop);
         dropped <= (push && full && !pop) || (dropped && !host_clear_drop);
         if (host_in_we) input_IO <= host_in_data;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= output_IO;
   end
endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: directed and random stimulus checked against a run-length/queue reference model
module tb_io_port_bridge;
   localparam int DEPTH = 8;
   localparam int SC = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [15:0] output_IO = '0, host_in_data = '0;
   logic host_in_we = 1'b0, host_rd_en = 1'b0, host_clear_drop = 1'b0;
   logic [15:0] input_IO, host_rd_data;
   logic host_rd_valid, dropped;
   logic [$clog2(DEPTH):0] fifo_count;
   int checks = 0;
   int failures = 0;
   string phase = "reset";
   logic [15:0] q [$];
   logic [15:0] last_m, prev_m, in_m;
   int run_m;
   logic drop_m;

   io_port_bridge #(.DEPTH(DEPTH), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .reset(reset), .output_IO(output_IO), .input_IO(input_IO),
      .host_in_data(host_in_data), .host_in_we(host_in_we), .host_rd_en(host_rd_en),
      .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid), .fifo_count(fifo_count),
      .dropped(dropped), .host_clear_drop(host_clear_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s/%s observed=0x%0h expected=0x%0h at %0t", phase, tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      last_m = '0;
      prev_m = '0;
      in_m = '0;
      run_m = 0;
      drop_m = 1'b0;
   endtask

   task automatic check_all();
      chk("valid", 32'(host_rd_valid), 32'(q.size() != 0));
      chk("data", 32'(host_rd_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
      chk("count", 32'(fifo_count), 32'(q.size()));
      chk("dropped", 32'(dropped), 32'(drop_m));
      chk("input_IO", 32'(input_IO), 32'(in_m));
   endtask

   // A value is captured once it has been seen SC samples in a row and differs from the last captured value.
   task automatic step(logic [15:0] o, logic rd = 1'b0, logic we = 1'b0, logic [15:0] d = '0, logic clr = 1'b0);
      bit cap, pop, lost;
      output_IO = o;
      host_rd_en = rd;
      host_in_we = we;
      host_in_data = d;
      host_clear_drop = clr;
      @(posedge clk);
      run_m = (run_m > 0 && o == prev_m) ? run_m + 1 : 1;
      prev_m = o;
      cap = run_m == SC && o != last_m;
      pop = rd && q.size() > 0;
      lost = 1'b0;
      if (pop) void'(q.pop_front());
      if (cap) begin
         last_m = o;
         if (q.size() < DEPTH) q.push_back(o);
         else lost = 1'b1;
      end
      if (clr) drop_m = 1'b0;
      if (lost) drop_m = 1'b1;
      if (we) in_m = d;
      #1;
      check_all();
   endtask

   initial begin
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      phase = "idle";
      repeat (20) step(16'h0000);
      chk("idle_count", 32'(fifo_count), 32'h0);
      phase = "basic";
      step(16'h1234);
      chk("no_push_yet", 32'(host_rd_valid), 32'h0);
      step(16'h1234);
      chk("head", 32'(host_rd_data), 32'h1234);
      chk("count1", 32'(fifo_count), 32'h1);
      step(16'h1234, 1'b1);
      chk("after_pop_valid", 32'(host_rd_valid), 32'h0);
      phase = "glitch";
      step(16'h00AA);
      step(16'h1234);
      step(16'h1234);
      chk("rejected", 32'(fifo_count), 32'h0);
      step(16'h00AA);
      step(16'h00BB);
      step(16'h00BB);
      chk("bb_head", 32'(host_rd_data), 32'h00BB);
      chk("bb_count", 32'(fifo_count), 32'h1);
      step(16'h00BB, 1'b1);
      phase = "overflow";
      for (int i = 1; i <= 9; i++) begin
         step(16'h0100 + 16'(i));
         step(16'h0100 + 16'(i));
      end
      chk("full_count", 32'(fifo_count), 32'h8);
      chk("drop_set", 32'(dropped), 32'h1);
      chk("first_head", 32'(host_rd_data), 32'h0101);
      step(16'h0109, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("drop_clr", 32'(dropped), 32'h0);
      step(16'h010A);
      step(16'h010A, 1'b1);
      chk("full_pushpop_count", 32'(fifo_count), 32'h8);
      chk("full_pushpop_nodrop", 32'(dropped), 32'h0);
      chk("second_head", 32'(host_rd_data), 32'h0102);
      repeat (8) step(16'h010A, 1'b1);
      phase = "wrap";
      for (int i = 1; i <= 20; i++) begin
         step(16'(i));
         step(16'(i));
         chk("wrap_head", 32'(host_rd_data), 32'(i));
         step(16'(i), 1'b1);
      end
      chk("wrap_empty", 32'(fifo_count), 32'h0);
      phase = "input";
      step(16'h0014, 1'b0, 1'b1, 16'hBEEF);
      chk("beef", 32'(input_IO), 32'hBEEF);
      phase = "midreset";
      for (int i = 0; i < 3; i++) begin
         step(16'h0031 + 16'(i));
         step(16'h0031 + 16'(i));
      end
      chk("three", 32'(fifo_count), 32'h3);
      step(16'h0044);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;
      step(16'h0055);
      step(16'h0055);
      chk("post_reset_head", 32'(host_rd_data), 32'h0055);
      phase = "random";
      begin
         logic [15:0] vals [4];
         logic [15:0] o;
         vals[0] = 16'h0000;
         vals[1] = 16'h0001;
         vals[2] = 16'h0002;
         vals[3] = 16'hA5A5;
         o = 16'h0;
         for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 2) == 0) o = vals[$urandom_range(0, 3)];
            step(o, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 15) == 0);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
